cdb_arbiter: RTL

- Transmitter side of the common data bus (CDB): collects completed results (tag + data) from functional units and broadcasts exactly one per cycle to the snoopers.
- Snoopers are the reservation stations, register file and ROB, which receive cdb_data.
- Each functional-unit source has a small FIFO with a valid/ready push port.
- A round-robin arbiter picks one non-empty FIFO head per cycle onto a registered CDB output.

---
 rtl/tomasula_types.sv | 22 ++
 rtl/cdb_src_fifo.sv | 72 +++++++
 rtl/cdb_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/tomasula_types.sv
// rtl/tomasula_types.sv - shared Tomasulo types: CDB payload, CDB source indexing
// Purpose : common CDB packet layout and source enumeration for the CDB transmitter.
// Contents: NUM_CDB_SRC, CDB_TAG_W, CDB_DATA_W, cdb_data (tag + data), cdb_src_t.
package tomasula_types;

  localparam int NUM_CDB_SRC = 4;
  localparam int CDB_TAG_W   = 3;
  localparam int CDB_DATA_W  = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_data;

  typedef enum logic [1:0] {
    SRC_ALU0,
    SRC_ALU1,
    SRC_LOAD,
    SRC_BR
  } cdb_src_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result FIFO feeding the CDB arbiter
// Purpose : small circular buffer of completed results for one functional unit.
// Ports   : clk, rst (async, active-high), flush (sync clear),
//           push/push_data (enqueue), pop (dequeue head),
//           head (current oldest entry), empty, full.
module cdb_src_fifo
  import tomasula_types::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    push,
  input  cdb_data push_data,
  input  logic    pop,
  output cdb_data head,
  output logic    empty,
  output logic    full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("cdb_src_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  cdb_data          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign head  = mem[rd_ptr];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB transmitter: per-source FIFOs + round-robin broadcast
// Purpose : buffers FU results and broadcasts one per cycle on a registered CDB.
// Ports   : clk, rst (async, active-high), flush_i (sync pipeline flush),
//           fu_valid_i/fu_data_i/fu_ready_o (per-source push ports),
//           cdb_valid_o/cdb_o (broadcast), cdb_src_o (granted source index).
module cdb_arbiter
  import tomasula_types::*;
#(
  parameter int NUM_SRC    = NUM_CDB_SRC,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = CDB_TAG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [NUM_SRC-1:0]         fu_valid_i,
  input  cdb_data [NUM_SRC-1:0]      fu_data_i,
  output logic [NUM_SRC-1:0]         fu_ready_o,
  output logic                       cdb_valid_o,
  output cdb_data                    cdb_o,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src_o
);

  localparam int SRC_W = $clog2(NUM_SRC);

  if (TAG_W != CDB_TAG_W) begin : g_tag_w_check
    $error("cdb_arbiter: TAG_W must match the cdb_data tag width");
  end

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] full;
  cdb_data            heads [NUM_SRC];
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   gnt;
  logic [SRC_W-1:0]   idx;
  logic               gnt_valid;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic empty;

    cdb_src_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .push      (push[i]),
      .push_data (fu_data_i[i]),
      .pop       (pop[i]),
      .head      (heads[i]),
      .empty     (empty),
      .full      (full[i])
    );

    assign req[i]        = !empty;
    // Ready comes from the registered count only: a full FIFO refuses a push
    // even in a cycle where it is also being popped.
    assign fu_ready_o[i] = !full[i] && !rst;
    assign push[i]       = fu_valid_i[i] && fu_ready_o[i];
    assign pop[i]        = gnt_valid && (gnt == SRC_W'(i));
  end

  // Scan from rr_ptr upward with wrap; iterating from the far end means the
  // requester closest to rr_ptr is the last assignment and therefore wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt       = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_o <= 1'b0;
      cdb_o       <= '0;
      cdb_src_o   <= '0;
      rr_ptr      <= '0;
    end else if (flush_i) begin
      // The grant computed this cycle is discarded along with the FIFOs.
      cdb_valid_o <= 1'b0;
      rr_ptr      <= '0;
    end else if (gnt_valid) begin
      cdb_valid_o <= 1'b1;
      cdb_o       <= heads[gnt];
      cdb_src_o   <= gnt;
      rr_ptr      <= SRC_W'((int'(gnt) + 1) % NUM_SRC);
    end else begin
      cdb_valid_o <= 1'b0;
    end
  end

endmodule
